// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: req/ack access port that one master presents to the RAM arbiter
interface ram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req, we, ack, err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;
    modport master(output req, we, addr, wdata, input ack, err, rdata);
    modport slave(input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between the SCPU (m0) and the debug/loader port (m1)
module ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RAM_AW = 10,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      m0,
    ram_arbiter_if.slave      m1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_n;
    logic gnt, gnt_n, we_q, we_n, err_q, err_n, take, pick, good_rd, unused_addr;
    logic [1:0] ack_q, err_o;
    logic [RAM_AW-1:0] wa_q, wa_n;
    logic [DATA_W-1:0] wd_q, wd_n, rd0, rd1;
    // gnt doubles as last_grant: on contention the master not served last time wins
    assign pick = m1.req & (~m0.req | (RR & ~gnt));
    assign take = (state == IDLE) & (m0.req | m1.req);
    assign good_rd = (state == RESP) & ~we_q & ~err_q;
    assign unused_addr = ^{m0.addr[ADDR_W-1:RAM_AW+2], m1.addr[ADDR_W-1:RAM_AW+2]};
    always_comb begin
        gnt_n = take ? pick : gnt;
        we_n = take ? (pick ? m1.we : m0.we) : we_q;
        err_n = take ? |(pick ? m1.addr[1:0] : m0.addr[1:0]) : err_q;
        wa_n = take ? (pick ? m1.addr[RAM_AW+1:2] : m0.addr[RAM_AW+1:2]) : wa_q;
        wd_n = take ? (pick ? m1.wdata : m0.wdata) : wd_q;
        state_n = take ? (err_n ? RESP : ACCESS) : (state == ACCESS ? RESP : IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= 1'b1;
            we_q <= 1'b0;
            err_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            ack_q <= 2'b00;
            err_o <= 2'b00;
            busy <= 1'b0;
            rd0 <= '0;
            rd1 <= '0;
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            we_q <= we_n;
            err_q <= err_n;
            wa_q <= wa_n;
            wd_q <= wd_n;
            ram_en <= state_n == ACCESS;
            ram_we <= (state_n == ACCESS) & we_n;
            ack_q <= (state_n == RESP) ? {gnt_n, ~gnt_n} : 2'b00;
            err_o <= ((state_n == RESP) & err_n) ? {gnt_n, ~gnt_n} : 2'b00;
            busy <= state_n != IDLE;
            if (good_rd & ~gnt) rd0 <= ram_rdata;
            if (good_rd & gnt) rd1 <= ram_rdata;
        end
    end
    // RAM data arrives in the RESP cycle, so it is passed through alongside ack and held afterwards
    assign m0.ack = ack_q[0];
    assign m1.ack = ack_q[1];
    assign m0.err = err_o[0];
    assign m1.err = err_o[1];
    assign m0.rdata = (good_rd & ~gnt) ? ram_rdata : rd0;
    assign m1.rdata = (good_rd & gnt) ? ram_rdata : rd1;
    assign ram_addr = wa_q;
    assign ram_wdata = wd_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed table, corner sequences and randomized traffic against a memory/arbitration model
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if m0(), m1(), f0(), f1();
    logic ram_en, ram_we, busy, f_en, f_we, f_busy;
    logic [9:0] ram_addr, f_addr;
    logic [31:0] ram_wdata, ram_rdata, f_wdata, f_rdata;
    assign f_rdata = 32'h0;

    ram_arbiter dut (
        .clk(clk), .rst(rst), .m0(m0), .m1(m1),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );
    ram_arbiter #(.RR(1'b0)) u_fp (
        .clk(clk), .rst(rst), .m0(f0), .m1(f1),
        .ram_en(f_en), .ram_we(f_we), .ram_addr(f_addr),
        .ram_wdata(f_wdata), .ram_rdata(f_rdata), .busy(f_busy)
    );

    function automatic logic [31:0] seed(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'hA5A50000;
    endfunction

    // synchronous RAM: read data valid the cycle after the strobe
    logic [31:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = seed(i);
        mem[4] = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_we) mem[ram_addr] <= ram_wdata;
                else ram_rdata <= mem[ram_addr];
            end
        end
    end

    int n0 = 0, n1 = 0;
    always @(negedge clk) begin
        if (f0.ack) n0++;
        if (f1.ack) n1++;
    end

    int tests = 0, fails = 0;
    logic [31:0] ref_mem [1024];
    logic [31:0] hold [2];
    bit last_m;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic txn(input logic [1:0] req, input bit w0, input bit w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input bit em, input bit ee, input logic [31:0] erd,
                       input logic [9:0] era, input bit ewe);
        logic [31:0] exp_rd;
        bit got;
        @(negedge clk);
        m0.req = req[0]; m0.we = w0; m0.addr = a0; m0.wdata = d0;
        m1.req = req[1]; m1.we = w1; m1.addr = a1; m1.wdata = d1;
        exp_rd = (ee || ewe) ? hold[em] : erd;
        got = 0;
        for (int k = 1; k <= 5 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("ram_en", ram_en, !ee);
                if (!ee) begin
                    chk("ram_addr", ram_addr, era);
                    chk("ram_we", ram_we, ewe);
                    if (ewe) chk("ram_wdata", ram_wdata, em ? d1 : d0);
                end
            end
            chk("ack_excl", m0.ack & m1.ack, 0);
            if (m0.ack | m1.ack) begin
                got = 1;
                chk("latency", k, ee ? 1 : 2);
                chk("ack_who", m1.ack, em);
                chk("err", em ? m1.err : m0.err, ee);
                chk("rdata", em ? m1.rdata : m0.rdata, exp_rd);
                chk("busy_resp", busy, 1);
            end
        end
        chk("ack_seen", got, 1);
        m0.req = 0;
        m1.req = 0;
        hold[em] = exp_rd;
        last_m = em;
        if (ewe && !ee) ref_mem[era] = em ? d1 : d0;
    endtask

    typedef struct packed {
        bit m; bit we; logic [31:0] addr; logic [31:0] wdata; bit err; logic [31:0] rd; logic [9:0] ra;
    } vec_t;

    initial begin : main
        vec_t tab [9];
        logic [1:0] rq;
        bit w0, w1, em, ee, ewe;
        logic [31:0] a0, a1, d0, d1;
        int wa0, wa1, o0, o1, cnt, prev, base;
        tab[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 10'd4};
        tab[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0, 10'd8};
        tab[2] = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678, 10'd8};
        tab[3] = '{1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 1'b1, 32'h0, 10'd4};
        tab[4] = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 10'd4};
        tab[5] = '{1'b0, 1'b0, 32'h1004, 32'h0, 1'b0, seed(1), 10'd1};
        tab[6] = '{1'b1, 1'b1, 32'h1008, 32'hCAFEF00D, 1'b0, 32'h0, 10'd2};
        tab[7] = '{1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'hCAFEF00D, 10'd2};
        tab[8] = '{1'b1, 1'b0, 32'h3FFC, 32'h0, 1'b0, seed(1023), 10'h3FF};
        for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);
        ref_mem[4] = 32'hDEADBEEF;
        hold[0] = 0; hold[1] = 0; last_m = 1;
        {m0.req, m0.we, m0.addr, m0.wdata} = '0;
        {m1.req, m1.we, m1.addr, m1.wdata} = '0;
        {f0.req, f0.we, f0.addr, f0.wdata} = '0;
        {f1.req, f1.we, f1.addr, f1.wdata} = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_acks", {m0.ack, m1.ack, m0.err, m1.err}, 0);
        chk("rst_rdata0", m0.rdata, 0);
        chk("rst_rdata1", m1.rdata, 0);
        rst = 0;

        foreach (tab[i])
            txn(tab[i].m ? 2'b10 : 2'b01, tab[i].we, tab[i].we, tab[i].addr, tab[i].addr,
                tab[i].wdata, tab[i].wdata, tab[i].m, tab[i].err, tab[i].rd, tab[i].ra, tab[i].we);
        chk("mem4_kept", ref_mem[4], 32'hDEADBEEF);

        // both masters held high: strict alternation starting at m0 after reset
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        hold[0] = 0; hold[1] = 0;
        m0.req = 1; m0.we = 0; m0.addr = 32'h10;
        m1.req = 1; m1.we = 0; m1.addr = 32'h20;
        cnt = 0; prev = 0;
        for (int c = 1; c <= 20 && cnt < 4; c++) begin
            @(negedge clk);
            chk("ack_excl", m0.ack & m1.ack, 0);
            if (m0.ack | m1.ack) begin
                chk("rr_who", m1.ack, cnt % 2);
                chk("rr_rdata", m1.ack ? m1.rdata : m0.rdata, m1.ack ? ref_mem[8] : ref_mem[4]);
                if (cnt > 0) chk("rr_gap", c - prev, 3);
                prev = c;
                cnt++;
            end
        end
        chk("rr_count", cnt, 4);
        m0.req = 0; m1.req = 0;
        hold[0] = ref_mem[4]; hold[1] = ref_mem[8]; last_m = 1;

        for (int i = 0; i < 150; i++) begin
            rq = 2'($urandom_range(1, 3));
            w0 = 1'($urandom); w1 = 1'($urandom);
            d0 = $urandom; d1 = $urandom;
            wa0 = $urandom_range(0, 15); wa1 = $urandom_range(0, 15);
            o0 = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            o1 = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            a0 = ($urandom & 32'hFFFFF000) | 32'(wa0 * 4 + o0);
            a1 = ($urandom & 32'hFFFFF000) | 32'(wa1 * 4 + o1);
            em = (rq == 2'b11) ? !last_m : (rq == 2'b10);
            ee = (em ? o1 : o0) != 0;
            ewe = em ? w1 : w0;
            txn(rq, w0, w1, a0, a1, d0, d1, em, ee, ref_mem[em ? wa1 : wa0],
                10'(em ? wa1 : wa0), ewe);
        end

        // reset while the RAM access is in flight
        @(negedge clk);
        m0.req = 1; m0.we = 0; m0.addr = 32'h10;
        @(negedge clk);
        chk("abort_access", ram_en, 1);
        rst = 1; m0.req = 0;
        @(negedge clk);
        chk("abort_acks", {m0.ack, m1.ack, m0.err, m1.err}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ram", {ram_en, ram_we, ram_addr}, 0);
        chk("abort_rdata", m0.rdata, 0);
        rst = 0;
        hold[0] = 0; hold[1] = 0; last_m = 1;
        @(negedge clk);
        chk("abort_noack", {m0.ack, m1.ack}, 0);
        txn(2'b10, 0, 0, 32'h0, 32'h20, 32'h0, 32'h0, 1, 0, ref_mem[8], 10'd8, 0);

        // fixed-priority instance: m1 starves while m0 keeps requesting
        base = n0;
        f0.req = 1; f1.req = 1;
        for (int c = 0; c < 20 && n0 - base < 4; c++) @(negedge clk);
        f0.req = 0; f1.req = 0;
        chk("fp_m0_grants", n0 - base, 4);
        chk("fp_m1_grants", n1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
